// File: rtl/control_unit_mc.sv
// Multi-cycle control unit for the 16-bit, 4-field instruction set
// (opcode[15:12], rd[11:8], ra[7:4], rb[3:0]).
//
// Each instruction is fetched as two bytes over a req/ready memory port. It then executes in
// one EXEC cycle. LOAD and STORE take one further MEM beat. The unit owns the program counter,
// the 16-entry register file and the C/G/E flags. The ALU outside this block is combinational.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   run               1 = fetch instructions, 0 = halt at the next instruction boundary
//   mem_*             unified program/data memory; request is held until mem_ready
//   alu_*             operands/opcode out, result and flags back from the external ALU
//   gpio_in           input port read by IN
//   gpio_out/_valid   registered output port, plus a one-cycle strobe on every OUT
//   halted            idle in FETCH_H with run low
//   pc                current program counter
module control_unit_mc #(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_greater,
  input  logic              alu_equal,
  input  logic [DATA_W-1:0] gpio_in,
  output logic [DATA_W-1:0] gpio_out,
  output logic              gpio_out_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [1:0] {StFetchH, StFetchL, StExec, StMem} state_e;

  localparam logic [3:0] OpAdd   = 4'h0;
  localparam logic [3:0] OpSub   = 4'h1;
  localparam logic [3:0] OpCmp   = 4'h5;
  localparam logic [3:0] OpLoad  = 4'h8;
  localparam logic [3:0] OpStore = 4'h9;
  localparam logic [3:0] OpJmp   = 4'hA;
  localparam logic [3:0] OpIn    = 4'hB;
  localparam logic [3:0] OpOut   = 4'hC;
  localparam logic [3:0] OpBeq   = 4'hD;
  localparam logic [3:0] OpBgt   = 4'hE;
  localparam logic [3:0] OpBc    = 4'hF;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic [DATA_W-1:0]   rf_q [16];
  logic                rf_we;
  logic [DATA_W-1:0]   rf_wdata;
  logic                c_q, c_d, g_q, g_d, e_q, e_d;
  logic [DATA_W-1:0]   gpio_q, gpio_d;
  logic                gpio_valid_q, gpio_valid_d;
  logic                req_int;

  logic [3:0]          op, rd, ra, rb;
  logic [ADDR_W-1:0]   imm_addr;
  logic [ADDR_W-1:0]   pc_inc;

  assign op     = ir_q[15:12];
  assign rd     = ir_q[11:8];
  assign ra     = ir_q[7:4];
  assign rb     = ir_q[3:0];
  assign pc_inc = pc_q + ADDR_W'(1);

  // Jump and data addresses are the 8-bit {ra,rb} field, zero-extended.
  always_comb begin
    imm_addr      = '0;
    imm_addr[7:0] = ir_q[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StFetchH;
      pc_q         <= PC_RESET;
      ir_q         <= '0;
      c_q          <= 1'b0;
      g_q          <= 1'b0;
      e_q          <= 1'b0;
      gpio_q       <= '0;
      gpio_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      c_q          <= c_d;
      g_q          <= g_d;
      e_q          <= e_d;
      gpio_q       <= gpio_d;
      gpio_valid_q <= gpio_valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_we) begin
      rf_q[rd] <= rf_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    c_d          = c_q;
    g_d          = g_q;
    e_d          = e_q;
    gpio_d       = gpio_q;
    gpio_valid_d = 1'b0;
    rf_we        = 1'b0;
    rf_wdata     = '0;
    req_int      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    unique case (state_q)
      StFetchH: begin
        // run is only looked at here, so a drop mid-instruction lets it finish.
        if (run) begin
          req_int  = 1'b1;
          mem_addr = pc_q;
          if (mem_ready) begin
            ir_d[15:8] = mem_rdata[7:0];
            pc_d       = pc_inc;
            state_d    = StFetchL;
          end
        end
      end

      StFetchL: begin
        req_int  = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          ir_d[7:0] = mem_rdata[7:0];
          pc_d      = pc_inc;
          state_d   = StExec;
        end
      end

      StExec: begin
        state_d = StFetchH;
        if (!op[3]) begin
          if (op == OpCmp) begin
            g_d = alu_greater;
            e_d = alu_equal;
          end else begin
            rf_we    = 1'b1;
            rf_wdata = alu_result;
          end
          if (op == OpAdd || op == OpSub) begin
            c_d = alu_carry;
          end
        end else begin
          case (op)
            OpLoad, OpStore: state_d = StMem;
            OpJmp:           pc_d = imm_addr;
            OpIn: begin
              rf_we    = 1'b1;
              rf_wdata = gpio_in;
            end
            OpOut: begin
              gpio_d       = rf_q[rd];
              gpio_valid_d = 1'b1;
            end
            // Flags are the values registered before this instruction.
            OpBeq:   if (e_q) pc_d = imm_addr;
            OpBgt:   if (g_q) pc_d = imm_addr;
            OpBc:    if (c_q) pc_d = imm_addr;
            default: ;
          endcase
        end
      end

      StMem: begin
        req_int  = 1'b1;
        mem_addr = imm_addr;
        if (op == OpStore) begin
          mem_we    = 1'b1;
          mem_wdata = rf_q[rd];
        end
        if (mem_ready) begin
          if (op == OpLoad) begin
            rf_we    = 1'b1;
            rf_wdata = mem_rdata;
          end
          state_d = StFetchH;
        end
      end

      default: state_d = StFetchH;
    endcase
  end

  // Gate with rst so an in-flight request is withdrawn the moment reset rises.
  assign mem_req        = req_int & ~rst;
  assign halted         = (state_q == StFetchH) & ~run;
  assign pc             = pc_q;
  assign alu_op         = op;
  assign alu_a          = rf_q[ra];
  assign alu_b          = rf_q[rb];
  assign gpio_out       = gpio_q;
  assign gpio_out_valid = gpio_valid_q;

endmodule

// File: tb/tb_control_unit_mc.sv
module tb_control_unit_mc;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;

  logic          clk, rst, run;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr, pc;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    alu_op;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic          alu_carry, alu_greater, alu_equal;
  logic [DW-1:0] gpio_in, gpio_out;
  logic          gpio_out_valid, halted;

  logic [7:0]    mem [256];
  logic [7:0]    gpio_log [$];
  int            checks = 0;
  int            errors = 0;

  control_unit_mc #(.DATA_W(DW), .ADDR_W(AW), .PC_RESET(8'h00)) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_greater(alu_greater), .alu_equal(alu_equal),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_out_valid(gpio_out_valid),
    .halted(halted), .pc(pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // External ALU: returns {carry, result}. SUB carry means "no borrow".
  function automatic logic [DW:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
    case (op)
      4'h0:    return {1'b0, a} + {1'b0, b};
      4'h1:    return {a >= b, a - b};
      4'h2:    return {1'b0, a & b};
      4'h3:    return {1'b0, a | b};
      4'h4:    return {1'b0, a ^ b};
      4'h5:    return {1'b0, a - b};
      4'h6:    return {a[DW-1], a << 1};
      4'h7:    return {1'b0, a >> 1};
      default: return {1'b0, a};
    endcase
  endfunction

  always_comb begin
    {alu_carry, alu_result} = alu_f(alu_op, alu_a, alu_b);
    alu_greater             = alu_a > alu_b;
    alu_equal               = alu_a == alu_b;
  end

  assign mem_rdata = mem[mem_addr];

  initial begin
    forever begin
      @(negedge clk);
      if (gpio_out_valid === 1'b1) gpio_log.push_back(gpio_out);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One clock; a write beat accepted at this edge lands in the memory model.
  task automatic step();
    logic       wr;
    logic [7:0] wa, wd;
    wr = mem_req && mem_we && mem_ready;
    wa = mem_addr;
    wd = mem_wdata;
    @(posedge clk);
    if (wr) mem[wa] = wd;
    #1;
  endtask

  task automatic do_reset();
    run       = 1'b0;
    mem_ready = 1'b1;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic put(input int addr, input logic [15:0] ins);
    mem[addr]     = ins[15:8];
    mem[addr + 1] = ins[7:0];
  endtask

  // Run exactly one instruction from a halted state; stall = wait cycles in FETCH_L.
  task automatic exec_one(input int stall, output int cyc);
    logic [AW-1:0] a0;
    cyc = 0;
    run = 1'b1;
    step();
    cyc++;
    run = 1'b0;
    a0  = mem_addr;
    for (int i = 0; i < stall; i++) begin
      mem_ready = 1'b0;
      chk("hold_req", 32'(mem_req), 32'd1);
      chk("hold_addr", 32'(mem_addr), 32'(a0));
      step();
      cyc++;
    end
    if (stall > 0) begin
      chk("hold_req", 32'(mem_req), 32'd1);
      chk("hold_addr", 32'(mem_addr), 32'(a0));
    end
    mem_ready = 1'b1;
    while (!halted && cyc < 50) begin
      step();
      cyc++;
    end
    if (!halted) chk("halt_timeout", 32'd0, 32'd1);
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] pre;
    logic [15:0] test;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  exp_rd;
    logic [7:0]  exp_pc;
    int          exp_lat;
  } vec_t;

  // Instruction-level reference model state.
  logic [7:0] m_reg [16];
  logic [7:0] m_mem [256];
  logic       m_c, m_g, m_e;
  logic [7:0] m_pc;
  logic [7:0] m_out [$];

  task automatic iss_run(input logic [7:0] p_end);
    logic [15:0] ins;
    logic [3:0]  op, rd;
    logic [7:0]  a, b, tgt, r;
    logic        cy;
    int          guard = 0;
    while (m_pc != p_end && guard < 1000) begin
      guard++;
      ins  = {m_mem[m_pc], m_mem[m_pc + 8'd1]};
      m_pc = m_pc + 8'd2;
      op   = ins[15:12];
      rd   = ins[11:8];
      tgt  = ins[7:0];
      a    = m_reg[ins[7:4]];
      b    = m_reg[ins[3:0]];
      if (op < 4'h8) begin
        {cy, r} = alu_f(op, a, b);
        if (op == 4'h5) begin
          m_g = a > b;
          m_e = a == b;
        end else begin
          m_reg[rd] = r;
        end
        if (op < 4'h2) m_c = cy;
      end else begin
        case (op)
          4'h8:    m_reg[rd] = m_mem[tgt];
          4'h9:    m_mem[tgt] = m_reg[rd];
          4'hA:    m_pc = tgt;
          4'hB:    m_reg[rd] = gpio_in;
          4'hC:    m_out.push_back(m_reg[rd]);
          4'hD:    if (m_e) m_pc = tgt;
          4'hE:    if (m_g) m_pc = tgt;
          default: if (m_c) m_pc = tgt;
        endcase
      end
    end
  endtask

  initial begin
    vec_t        vecs [18];
    int          cyc, base, nmis, exp_n;
    logic [15:0] outi;
    logic [7:0]  p_end;
    logic [3:0]  rop;

    vecs[0]  = '{16'h2000, 16'h0123, 8'h05, 8'h07, 8'h0C, 8'h08, 3};
    vecs[1]  = '{16'h2000, 16'h1123, 8'h09, 8'h03, 8'h06, 8'h08, 3};
    vecs[2]  = '{16'h2000, 16'h4123, 8'h5A, 8'hFF, 8'hA5, 8'h08, 3};
    vecs[3]  = '{16'h2000, 16'h6123, 8'h81, 8'h00, 8'h02, 8'h08, 3};
    vecs[4]  = '{16'h2000, 16'h0223, 8'h05, 8'h07, 8'h0C, 8'h08, 3};
    vecs[5]  = '{16'h2000, 16'h5123, 8'h09, 8'h09, 8'h00, 8'h08, 3};
    vecs[6]  = '{16'h5023, 16'hD120, 8'h09, 8'h09, 8'h00, 8'h20, 3};
    vecs[7]  = '{16'h5023, 16'hD120, 8'h03, 8'h09, 8'h00, 8'h08, 3};
    vecs[8]  = '{16'h5023, 16'hE120, 8'h03, 8'h09, 8'h00, 8'h08, 3};
    vecs[9]  = '{16'h5023, 16'hE120, 8'h09, 8'h03, 8'h00, 8'h20, 3};
    vecs[10] = '{16'h0023, 16'hF120, 8'hF0, 8'h20, 8'h00, 8'h20, 3};
    vecs[11] = '{16'h0023, 16'hF120, 8'h01, 8'h02, 8'h00, 8'h08, 3};
    vecs[12] = '{16'h2000, 16'hA120, 8'h00, 8'h00, 8'h00, 8'h20, 3};
    vecs[13] = '{16'h2000, 16'hB100, 8'h00, 8'h00, 8'hC3, 8'h08, 3};
    vecs[14] = '{16'h2000, 16'h923C, 8'hA5, 8'h00, 8'hA5, 8'h08, 4};
    vecs[15] = '{16'h923C, 16'h863C, 8'hA5, 8'h00, 8'hA5, 8'h08, 4};
    vecs[16] = '{16'h2000, 16'hC200, 8'h5A, 8'h00, 8'h5A, 8'h08, 3};
    vecs[17] = '{16'h1023, 16'hF120, 8'h09, 8'h03, 8'h00, 8'h20, 3};

    gpio_in = 8'hC3;
    clear_mem();
    rst = 1'b1;
    run = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("rst_req_async", 32'(mem_req), 32'd0);
    do_reset();
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_gpio", 32'(gpio_out), 32'd0);
    chk("rst_gpio_valid", 32'(gpio_out_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd1);

    // Single-instruction vectors: R2=a, R3=b, pre at 4, test at 6, OUT R[rd] at 8 and 0x20.
    foreach (vecs[v]) begin
      do_reset();
      clear_mem();
      mem[8'hF0] = vecs[v].a;
      mem[8'hF1] = vecs[v].b;
      outi = {4'hC, vecs[v].test[11:8], 8'h00};
      put(0, 16'h82F0);
      put(2, 16'h83F1);
      put(4, vecs[v].pre);
      put(6, vecs[v].test);
      put(8, outi);
      put(32, outi);
      base = gpio_log.size();
      exec_one(0, cyc);
      exec_one(0, cyc);
      exec_one(0, cyc);
      exec_one(0, cyc);
      chk($sformatf("v%0d_latency", v), 32'(cyc), 32'(vecs[v].exp_lat));
      chk($sformatf("v%0d_pc", v), 32'(pc), 32'(vecs[v].exp_pc));
      exec_one(0, cyc);
      chk($sformatf("v%0d_rd", v), 32'(gpio_out), 32'(vecs[v].exp_rd));
      chk($sformatf("v%0d_pulses", v), 32'(gpio_log.size() - base),
          (vecs[v].test[15:12] == 4'hC) ? 32'd2 : 32'd1);
      if (vecs[v].test[15:12] == 4'h9 || vecs[v].pre[15:12] == 4'h9)
        chk($sformatf("v%0d_store", v), 32'(mem[8'h3C]), 32'(vecs[v].a));
    end

    // Two wait states in FETCH_L stretch the instruction to 5 cycles.
    do_reset();
    clear_mem();
    put(0, 16'h0123);
    exec_one(2, cyc);
    chk("stall_latency", 32'(cyc), 32'd5);
    chk("stall_pc", 32'(pc), 32'd2);

    // OUT, halt for a while, resume at the same pc.
    do_reset();
    clear_mem();
    mem[8'hF0] = 8'h5A;
    put(0, 16'h87F0);
    put(2, 16'hC700);
    exec_one(0, cyc);
    base = gpio_log.size();
    exec_one(0, cyc);
    chk("out_value", 32'(gpio_out), 32'h5A);
    chk("out_pulse", 32'(gpio_log.size() - base), 32'd1);
    chk("halt_flag", 32'(halted), 32'd1);
    repeat (3) step();
    chk("halt_req", 32'(mem_req), 32'd0);
    chk("halt_pc", 32'(pc), 32'd4);
    run = 1'b1;
    #1;
    chk("resume_req", 32'(mem_req), 32'd1);
    chk("resume_addr", 32'(mem_addr), 32'd4);

    // Reset during a LOAD wait state.
    do_reset();
    clear_mem();
    mem[8'hF0] = 8'h77;
    put(0, 16'h85F0);
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    step();
    mem_ready = 1'b0;
    chk("ld_wait_req", 32'(mem_req), 32'd1);
    chk("ld_wait_addr", 32'(mem_addr), 32'hF0);
    step();
    chk("ld_wait_req2", 32'(mem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ld_rst_req", 32'(mem_req), 32'd0);
    chk("ld_rst_pc", 32'(pc), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    put(0, 16'hC500);
    base = gpio_log.size();
    exec_one(0, cyc);
    chk("ld_rst_rd", 32'(gpio_out), 32'd0);
    chk("ld_rst_pulse", 32'(gpio_log.size() - base), 32'd1);

    // Random programs with random wait states against the instruction-level model.
    for (int it = 0; it < 6; it++) begin
      do_reset();
      clear_mem();
      gpio_in = 8'($urandom_range(0, 255));
      for (int i = 192; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 20; i++) begin
        rop = 4'($urandom_range(0, 15));
        if (rop == 4'hA || rop >= 4'hD)
          put(2 * i, {rop, 4'($urandom_range(0, 15)), 8'(2 * $urandom_range(i + 1, 20))});
        else if (rop == 4'h8 || rop == 4'h9)
          put(2 * i, {rop, 4'($urandom_range(0, 15)), 2'b11, 6'($urandom_range(0, 63))});
        else
          put(2 * i, 16'($urandom_range(0, 65535)) & 16'h0FFF | {rop, 12'h000});
      end
      for (int i = 0; i < 16; i++) put(2 * (20 + i), {4'hC, 4'(i), 8'h00});
      p_end = 8'(2 * 36);
      put(int'(p_end), {4'hA, 4'h0, p_end});

      for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
      for (int i = 0; i < 256; i++) m_mem[i] = mem[i];
      m_c = 1'b0; m_g = 1'b0; m_e = 1'b0; m_pc = 8'h00;
      m_out.delete();
      iss_run(p_end);
      exp_n = m_out.size();

      base = gpio_log.size();
      cyc  = 0;
      run  = 1'b1;
      while ((gpio_log.size() - base) < exp_n && cyc < 5000) begin
        mem_ready = ($urandom_range(0, 3) != 0);
        step();
        cyc++;
      end
      run = 1'b0;
      while (!halted && cyc < 5000) begin
        mem_ready = ($urandom_range(0, 3) != 0);
        step();
        cyc++;
      end
      mem_ready = 1'b1;
      chk($sformatf("rand%0d_done", it), 32'(halted), 32'd1);
      chk($sformatf("rand%0d_pc", it), 32'(pc), 32'(p_end));
      chk($sformatf("rand%0d_nout", it), 32'(gpio_log.size() - base), 32'(exp_n));
      nmis = 0;
      for (int i = 0; i < exp_n && (base + i) < gpio_log.size(); i++)
        if (gpio_log[base + i] !== m_out[i]) nmis++;
      chk($sformatf("rand%0d_out_mismatches", it), 32'(nmis), 32'd0);
      nmis = 0;
      for (int i = 192; i < 256; i++) if (mem[i] !== m_mem[i]) nmis++;
      chk($sformatf("rand%0d_mem_mismatches", it), 32'(nmis), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
